wave_pattern_gen: RTL and testbench
===================================

Name: wave_pattern_gen

Overview:
- Multi-channel, parametrised waveform stimulus generator for waveform-sample designs.
- Each of NUM_CH channels produces a WIDTH-bit pattern. The pattern is selected per channel: hold, count up, count down, LFSR, walking-one, toggle, or LFSR with periodic X/Z injection.
- A start/stop FSM controls runs, with programmable sample rate and burst length.
- All patterns are deterministic, so the bench predicts every value exactly.

Parameters:
- WIDTH, 32: bits per channel.
- NUM_CH, 4: number of channels.
- POLY, 32'h8020_0003: Galois LFSR feedback mask; WIDTH bits used.
- SEED, 32'hACE1_2468: LFSR base seed. Channel c seeds with SEED^c; a zero result is forced to 1.
- XZ_PERIOD, 16: sample interval for X/Z injection in mode 6. Must be ≥2.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-low
- start  input  1  pulse; begins a run
- stop  input  1  pulse; aborts a run
- mode  input  NUM_CH*3  per-channel pattern select; channel c uses bits [3c+2:3c]
- rate_div  input  8  advance every rate_div+1 cycles
- burst_len  input  16  samples per run; 0 means infinite
- busy  output  1  FSM in RUN
- done  output  1  one-cycle pulse when a burst completes
- sample_valid  output  1  out_* hold a newly advanced sample this cycle
- sample_cnt  output  16  samples produced in the current run
- out_data  output  NUM_CH*WIDTH  2-state pattern values
- out_xmask  output  NUM_CH*WIDTH  bits to present as X
- out_zmask  output  NUM_CH*WIDTH  bits to present as Z
- out_wave  output  NUM_CH*WIDTH  4-state view (simulation only)

Behaviour:
- Reset (reset=0 at a clk edge): FSM goes to IDLE.
  - All outputs become 0: masks 0, out_wave 0, sample_cnt 0.
  - The divider counter becomes 0.
  - Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start & !stop → RUN.
  - RUN + stop → IDLE; outputs hold their last value.
  - RUN + final tick → DONE.
  - start while in RUN is ignored.
  - start & stop in the same cycle in IDLE/DONE: stay put (stop wins).
- On the start edge:
  - mode is latched into mode_q; mode changes during a run are ignored.
  - Channel registers load their init values; masks clear; sample_cnt=0; divider=0.
  - sample_valid stays 0 on the load.
- Tick: asserted in RUN when divider==rate_div. The divider resets to 0 on a tick, otherwise increments. rate_div=0 means a tick every RUN cycle.
- On each tick, every channel advances and sample_cnt increments (wraps at 16 bits in infinite mode).
  - sample_valid is high in the cycle after each tick, i.e. when the new value is visible.
  - Latency: the first advanced sample is visible 2 cycles after start is sampled.
- Burst end: the tick that makes sample_cnt==burst_len (burst_len≠0) moves the FSM to DONE.
  - done=1 and busy=0 in that same visible cycle.
  - Outputs hold until the next start.
- Modes (per channel; init value / advance rule):
  - 0 HOLD: init 0 / unchanged.
  - 1 COUNT_UP: init 0 / +1, wrapping all-ones→0.
  - 2 COUNT_DOWN: init all-ones / −1, wrapping 0→all-ones.
  - 3 LFSR: init seed / if lsb=1 then (s>>1)^POLY, else s>>1.
  - 4 WALK_ONE: init 1 / rotate left by 1; MSB returns to bit 0.
  - 5 TOGGLE: init alternating 0101… (bit0=1) / bitwise invert.
  - 6 XZ_INJECT: data as LFSR. On each sample whose new sample_cnt is a multiple of XZ_PERIOD, low min(4,WIDTH) bits are flagged:
    - xmask on odd multiples, zmask on even multiples.
    - Both masks clear on the next sample.
  - 7 reserved: behaves as HOLD.
- Mask rules: xmask and zmask are never set on the same bit. Both are zero in every mode except 6.
- out_wave per bit: 1'bx if xmask, else 1'bz if zmask, else out_data.

Test Plan:
- WIDTH=8, NUM_CH=4, ch0 mode 1, burst_len=5, rate_div=0, start at cycle 10 → ch0=00 at 11; sample_valid in cycles 12–16 with values 01..05; busy in 11–15; done only at 16; sample_cnt=5 held.
- ch1 mode 2, ch2 mode 4, burst_len=9 → ch1 goes FF,FE,…,F6; ch2 goes 01,02,04,…,80,01 (wraps at the 8th advance).
- rate_div=2, burst_len=3, ch0 mode 1 → sample_valid exactly every 3rd cycle, 3 times; values 01,02,03.
- WIDTH=8, POLY=8'hB8, SEED=8'h01, ch0 mode 3 → sequence B8,5C,2E,17,B3…; returns to 01 after exactly 255 samples.
- XZ_PERIOD=4, ch3 mode 6 → sample 4: xmask=0F and out_wave[3:0]=xxxx; sample 5: masks 0; sample 8: zmask=0F and out_wave[3:0]=zzzz.
- stop at the 3rd sample → IDLE next cycle, no done, outputs held. start+stop together in IDLE → stays IDLE. reset=0 mid-run → all outputs 0 next cycle.

Source files
------------

// File: rtl/wave_pattern_gen.sv
// Multi-channel deterministic waveform generator with start/stop burst control.
// All channels advance together on a programmable-rate tick; mode 6 overlays periodic X/Z flags.
module wave_pattern_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      NUM_CH    = 4,
    parameter logic [WIDTH-1:0] POLY      = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED      = 32'hACE1_2468,
    parameter int unsigned      XZ_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_CH*3-1:0]     mode,
    input  logic [7:0]              rate_div,
    input  logic [15:0]             burst_len,
    output logic                    busy,
    output logic                    done,
    output logic                    sample_valid,
    output logic [15:0]             sample_cnt,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*WIDTH-1:0] out_xmask,
    output logic [NUM_CH*WIDTH-1:0] out_zmask,
    output logic [NUM_CH*WIDTH-1:0] out_wave
);

    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam int unsigned      MaskBits = (WIDTH < 4) ? WIDTH : 4;
    localparam logic [WIDTH-1:0] MaskLow  = WIDTH'((64'd1 << MaskBits) - 64'd1);
    localparam logic [15:0]      XzPer    = 16'(XZ_PERIOD);

    function automatic logic [WIDTH-1:0] toggle_pattern();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < int'(WIDTH); i++) begin
            v[i] = (i % 2 == 0);
        end
        return v;
    endfunction

    localparam logic [WIDTH-1:0] ToggleInit = toggle_pattern();

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [WIDTH-1:0] chan_seed(input int unsigned c);
        logic [WIDTH-1:0] s;
        s = SEED ^ WIDTH'(c);
        return (s == '0) ? One : s;
    endfunction

    function automatic logic [WIDTH-1:0] init_val(input logic [2:0] m, input int unsigned c);
        case (m)
            3'd2:       return '1;
            3'd3, 3'd6: return chan_seed(c);
            3'd4:       return One;
            3'd5:       return ToggleInit;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] next_val(input logic [2:0] m, input logic [WIDTH-1:0] v);
        case (m)
            3'd1:       return v + One;
            3'd2:       return v - One;
            3'd3, 3'd6: return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
            3'd4:       return {v[WIDTH-2:0], v[WIDTH-1]};
            3'd5:       return ~v;
            default:    return v;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q, state_d;
    logic [7:0]                div_q, div_d;
    logic [15:0]               cnt_q, cnt_d, cnt_next;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic [NUM_CH*3-1:0]       mode_q, mode_d;
    logic [NUM_CH*WIDTH-1:0]   data_q, data_d;
    logic [NUM_CH*WIDTH-1:0]   xmask_q, xmask_d;
    logic [NUM_CH*WIDTH-1:0]   zmask_q, zmask_d;
    logic                      load, tick, xz_hit, xz_odd;

    assign cnt_next = cnt_q + 16'd1;
    assign xz_hit   = (cnt_next % XzPer) == 16'd0;
    assign xz_odd   = ((cnt_next / XzPer) & 16'd1) != 16'd0;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tick    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start && !stop) begin
                    state_d = StRun;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (div_q == rate_div) begin
                    tick = 1'b1;
                    if (burst_len != 16'd0 && cnt_next == burst_len) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        data_d  = data_q;
        xmask_d = xmask_q;
        zmask_d = zmask_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        valid_d = tick;
        done_d  = tick && (state_d == StDone);
        if (load) begin
            mode_d  = mode;
            cnt_d   = 16'd0;
            div_d   = 8'd0;
            xmask_d = '0;
            zmask_d = '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                data_d[c*WIDTH +: WIDTH] = init_val(mode[c*3 +: 3], c);
            end
        end else if (state_q == StRun && !stop) begin
            if (tick) begin
                div_d = 8'd0;
                cnt_d = cnt_next;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    data_d[c*WIDTH +: WIDTH] =
                        next_val(mode_q[c*3 +: 3], data_q[c*WIDTH +: WIDTH]);
                    xmask_d[c*WIDTH +: WIDTH] = '0;
                    zmask_d[c*WIDTH +: WIDTH] = '0;
                    // Odd multiples of the period flag X, even multiples flag Z.
                    if (mode_q[c*3 +: 3] == 3'd6 && xz_hit) begin
                        if (xz_odd) begin
                            xmask_d[c*WIDTH +: WIDTH] = MaskLow;
                        end else begin
                            zmask_d[c*WIDTH +: WIDTH] = MaskLow;
                        end
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            cnt_q   <= 16'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            data_q  <= '0;
            xmask_q <= '0;
            zmask_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            xmask_q <= xmask_d;
            zmask_q <= zmask_d;
        end
    end

    assign busy         = (state_q == StRun);
    assign done         = done_q;
    assign sample_valid = valid_q;
    assign sample_cnt   = cnt_q;
    assign out_data     = data_q;
    assign out_xmask    = xmask_q;
    assign out_zmask    = zmask_q;

    for (genvar b = 0; b < NUM_CH*WIDTH; b++) begin : g_wave
        assign out_wave[b] = zmask_q[b] ? 1'bz : (xmask_q[b] ? 1'bx : data_q[b]);
    end

endmodule

// File: tb/tb_wave_pattern_gen.sv
// Scoreboard bench for wave_pattern_gen: stimulus queues expected samples, a negedge monitor
// pops and compares every presented sample; directed checks cover load, done, stop and reset.
module tb_wave_pattern_gen;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [11:0] mode;
    logic [7:0]  rate_div;
    logic [15:0] burst_len;
    logic        busy, done, sample_valid;
    logic [15:0] sample_cnt;
    logic [31:0] out_data, out_xmask, out_zmask, out_wave;

    wave_pattern_gen #(
        .WIDTH    (8),
        .NUM_CH   (4),
        .POLY     (8'hB8),
        .SEED     (8'h01),
        .XZ_PERIOD(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .rate_div    (rate_div),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .sample_valid(sample_valid),
        .sample_cnt  (sample_cnt),
        .out_data    (out_data),
        .out_xmask   (out_xmask),
        .out_zmask   (out_zmask),
        .out_wave    (out_wave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] xm;
        logic [31:0] zm;
        logic [15:0] cnt;
        logic        done;
    } exp_t;

    exp_t       exp_q[$];
    int         stamp_q[$];
    logic [7:0] ch0_log[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] m_init(input logic [2:0] m, input int c);
        logic [7:0] s;
        s = 8'h01 ^ 8'(c);
        if (s == 8'h00) s = 8'h01;
        case (m)
            3'd2:       return 8'hFF;
            3'd3, 3'd6: return s;
            3'd4:       return 8'h01;
            3'd5:       return 8'h55;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] m_adv(input logic [2:0] m, input logic [7:0] v);
        case (m)
            3'd1:       return v + 8'd1;
            3'd2:       return v - 8'd1;
            3'd3, 3'd6: return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
            3'd4:       return {v[6:0], v[7]};
            3'd5:       return ~v;
            default:    return v;
        endcase
    endfunction

    task automatic plan_run(input logic [11:0] m, input int n, input int burst);
        logic [31:0] d;
        exp_t        e;
        for (int c = 0; c < 4; c++) d[c*8 +: 8] = m_init(m[c*3 +: 3], c);
        for (int k = 1; k <= n; k++) begin
            e = '0;
            for (int c = 0; c < 4; c++) begin
                d[c*8 +: 8] = m_adv(m[c*3 +: 3], d[c*8 +: 8]);
                if (m[c*3 +: 3] == 3'd6 && k % 4 == 0) begin
                    if ((k / 4) % 2 == 1) e.xm[c*8 +: 4] = 4'hF;
                    else                  e.zm[c*8 +: 4] = 4'hF;
                end
            end
            e.data = d;
            e.cnt  = 16'(k);
            e.done = (burst != 0 && k == burst);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            stamp_q.push_back(cyc);
            ch0_log.push_back(out_data[7:0]);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_sample: got sample_cnt=%0d with empty queue, expected none",
                         sample_cnt);
            end else begin
                e = exp_q.pop_front();
                check("smp_data", out_data, e.data);
                check("smp_xmask", out_xmask, e.xm);
                check("smp_zmask", out_zmask, e.zm);
                check("smp_cnt", sample_cnt, e.cnt);
                check("smp_done", done, e.done);
                check("smp_busy", busy, !e.done);
                check("smp_wave_ch0", out_wave[7:0], e.data[7:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (!done && i < budget) begin
            step();
            i++;
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        mode = '0; rate_div = 8'd0; burst_len = 16'd0;
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_cnt", sample_cnt, 16'd0);
        check("rst_data", out_data, 32'h0);
        reset = 1'b1;
        step();

        // Burst of 5: count up, count down, walking one, X/Z inject.
        mode = {3'd6, 3'd4, 3'd2, 3'd1};
        burst_len = 16'd5;
        plan_run(mode, 5, 5);
        pulse_start();
        check("a_load_busy", busy, 1'b1);
        check("a_load_valid", sample_valid, 1'b0);
        check("a_load_data", out_data, 32'h0201FF00);
        check("a_load_cnt", sample_cnt, 16'd0);
        wait_done(10, "a_done_seen");
        step();
        check("a_done_pulse", done, 1'b0);
        check("a_hold_busy", busy, 1'b0);
        check("a_hold_cnt", sample_cnt, 16'd5);
        check("a_hold_data", out_data, 32'h1720FA05);
        check("a_queue", exp_q.size(), 0);

        // Burst of 9 restarted from DONE; walking one wraps, Z at sample 8.
        burst_len = 16'd9;
        plan_run(mode, 9, 9);
        pulse_start();
        wait_done(15, "b_done_seen");
        step();
        check("b_hold_data", out_data, 32'h6402F609);
        check("b_hold_masks", {out_xmask, out_zmask}, 64'h0);
        check("b_queue", exp_q.size(), 0);

        // rate_div=2: one sample every third cycle.
        mode = 12'o0001;
        rate_div = 8'd2;
        burst_len = 16'd3;
        stamp_q.delete();
        plan_run(mode, 3, 3);
        pulse_start();
        wait_done(20, "c_done_seen");
        step();
        check("c_nsamples", stamp_q.size(), 3);
        if (stamp_q.size() == 3) begin
            check("c_gap1", stamp_q[1] - stamp_q[0], 3);
            check("c_gap2", stamp_q[2] - stamp_q[1], 3);
        end
        check("c_queue", exp_q.size(), 0);

        // LFSR full period, with reserved, toggle and X/Z channels alongside.
        mode = {3'd6, 3'd5, 3'd7, 3'd3};
        rate_div = 8'd0;
        burst_len = 16'd255;
        ch0_log.delete();
        plan_run(mode, 255, 255);
        pulse_start();
        wait_done(300, "d_done_seen");
        step();
        check("d_nsamples", ch0_log.size(), 255);
        if (ch0_log.size() >= 5) begin
            check("d_lfsr0", ch0_log[0], 8'hB8);
            check("d_lfsr1", ch0_log[1], 8'h5C);
            check("d_lfsr2", ch0_log[2], 8'h2E);
            check("d_lfsr3", ch0_log[3], 8'h17);
            check("d_lfsr4", ch0_log[4], 8'hB3);
        end
        check("d_lfsr_period", out_data[7:0], 8'h01);
        check("d_queue", exp_q.size(), 0);

        // Infinite run stopped while the third sample is visible.
        mode = 12'o0001;
        burst_len = 16'd0;
        plan_run(mode, 3, 0);
        pulse_start();
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("e_stop_busy", busy, 1'b0);
        check("e_stop_done", done, 1'b0);
        check("e_stop_valid", sample_valid, 1'b0);
        check("e_stop_data", out_data, 32'h03);
        check("e_stop_cnt", sample_cnt, 16'd3);
        repeat (2) step();
        check("e_hold_data", out_data, 32'h03);
        check("e_queue", exp_q.size(), 0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("f_busy", busy, 1'b0);
        step();
        check("f_busy_later", busy, 1'b0);
        check("f_data", out_data, 32'h03);

        // Reset in the middle of a run.
        mode = {3'd6, 3'd0, 3'd0, 3'd1};
        plan_run(mode, 2, 0);
        pulse_start();
        repeat (2) step();
        reset = 1'b0;
        step();
        check("g_busy", busy, 1'b0);
        check("g_done", done, 1'b0);
        check("g_valid", sample_valid, 1'b0);
        check("g_cnt", sample_cnt, 16'd0);
        check("g_data", out_data, 32'h0);
        check("g_masks", {out_xmask, out_zmask}, 64'h0);
        check("g_wave", out_wave, 32'h0);
        reset = 1'b1;
        step();
        check("g_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
